// File: rtl/pb_event_pkg.sv
// Shared constants for the pushbutton event FSM: state encoding and default timing.
package pb_event_pkg;

   localparam logic [2:0] IDLE           = 3'd0;
   localparam logic [2:0] PRESSED        = 3'd1;
   localparam logic [2:0] LONG_HELD      = 3'd2;
   localparam logic [2:0] WAIT_SECOND    = 3'd3;
   localparam logic [2:0] SECOND_PRESSED = 3'd4;

   localparam int LONG_CYCLES_DEF = 100;
   localparam int GAP_CYCLES_DEF  = 30;

endpackage

// File: rtl/pb_edge_detect.sv
// Rise/fall detector for a debounced level; the previous level resets high so a
// level held through reset never reports a rise.
module pb_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic level_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) level_prev <= 1'b1;
      else        level_prev <= level;
   end

   assign rise = level & ~level_prev;
   assign fall = ~level & level_prev;

endmodule

// File: rtl/pb_event_fsm.sv
// Converts a debounced pushbutton level into registered press/release/click/
// double/long event pulses plus a held level.
module pb_event_fsm
   import pb_event_pkg::*;
#(
   parameter int LONG_CYCLES = LONG_CYCLES_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_debounced,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             rise;
   logic             fall;
   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [CNT_W-1:0] cnt;
   logic             press_nx;
   logic             release_nx;
   logic             click_nx;
   logic             double_nx;
   logic             long_nx;
   logic             held_nx;

   pb_edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (pb_debounced),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      state_nx   = state;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      click_nx   = 1'b0;
      double_nx  = 1'b0;
      long_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nx = PRESSED;
               press_nx = 1'b1;
            end
         end
         PRESSED: begin
            // A release on the same edge as the long threshold wins.
            if (fall) begin
               state_nx   = WAIT_SECOND;
               release_nx = 1'b1;
            end else if (cnt == LONG_LAST) begin
               state_nx = LONG_HELD;
               long_nx  = 1'b1;
            end
         end
         LONG_HELD: begin
            if (fall) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
            end
         end
         WAIT_SECOND: begin
            // A re-press on the same edge as the gap timeout wins.
            if (rise) begin
               state_nx  = SECOND_PRESSED;
               press_nx  = 1'b1;
               double_nx = 1'b1;
            end else if (cnt == GAP_LAST) begin
               state_nx = IDLE;
               click_nx = 1'b1;
            end
         end
         SECOND_PRESSED: begin
            if (fall) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      held_nx = (state_nx == PRESSED) || (state_nx == LONG_HELD) ||
                (state_nx == SECOND_PRESSED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         double_pulse  <= 1'b0;
         long_pulse    <= 1'b0;
         held          <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx != state)  cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         click_pulse   <= click_nx;
         double_pulse  <= double_nx;
         long_pulse    <= long_nx;
         held          <= held_nx;
      end
   end

endmodule
